// File: rtl/dmem_arb_pkg.sv
// Shared types for the two-port data-memory arbiter.
package dmem_arb_pkg;

  typedef enum logic {
    ARB  = 1'b0,
    LOCK = 1'b1
  } arb_state_t;

  localparam int P_CPU = 0;
  localparam int P_DBG = 1;

endpackage

// File: rtl/dmem_arbiter_if.sv
// One requester port of the data-memory arbiter: request, accept and read response.
interface dmem_arbiter_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 16
);
  logic              valid;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              ready;
  logic              rvalid;
  logic [DATA_W-1:0] rdata;

  modport master (output valid, we, addr, wdata, input ready, rvalid, rdata);
  modport slave  (input valid, we, addr, wdata, output ready, rvalid, rdata);
endinterface

// File: rtl/arb_rr2.sv
// Combinational two-way round-robin pick: on contention the port that did not win last is granted.
module arb_rr2
  import dmem_arb_pkg::*;
(
  input  logic [1:0] valid,
  input  logic       last_grant,
  output logic [1:0] grant
);

  always_comb begin
    grant = valid;
    if (valid == 2'b11) begin
      grant = 2'b00;
      if (last_grant) grant[P_CPU] = 1'b1;
      else            grant[P_DBG] = 1'b1;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Arbitrates CPU (port 0) and debug/DMA (port 1) onto one single-cycle data memory,
// with round-robin fairness and a bounded exclusive lock for port 1.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W   = 4,
  parameter int DATA_W   = 16,
  parameter int LOCK_MAX = 8
) (
  input  logic              clk,
  input  logic              reset,
  dmem_arbiter_if.slave     p0,
  dmem_arbiter_if.slave     p1,
  input  logic              p1_lock,
  output logic              locked,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int CNT_W = $clog2(LOCK_MAX + 1);

  arb_state_t       state, state_nxt;
  logic             last_grant, last_grant_nxt;
  logic [CNT_W-1:0] lock_cnt, lock_cnt_nxt;
  logic             rd_pend, rd_owner;
  logic [1:0]       rr_grant, grant;

  arb_rr2 u_rr (
    .valid      ({p1.valid, p0.valid}),
    .last_grant (last_grant),
    .grant      (rr_grant)
  );

  // Reset gates every grant so nothing is accepted while reset is low.
  always_comb begin
    grant = 2'b00;
    if (reset) begin
      if (state == LOCK) grant[P_DBG] = p1.valid;
      else               grant = rr_grant;
    end
  end

  assign p0.ready = grant[P_CPU];
  assign p1.ready = grant[P_DBG];
  assign mem_en   = |grant;
  assign locked   = reset && (state == LOCK);

  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (grant[P_DBG]) begin
      mem_we    = p1.we;
      mem_addr  = p1.addr;
      mem_wdata = p1.wdata;
    end else if (grant[P_CPU]) begin
      mem_we    = p0.we;
      mem_addr  = p0.addr;
      mem_wdata = p0.wdata;
    end
  end

  always_comb begin
    state_nxt      = state;
    last_grant_nxt = last_grant;
    lock_cnt_nxt   = lock_cnt;
    if (grant[P_CPU]) last_grant_nxt = 1'b0;
    if (grant[P_DBG]) last_grant_nxt = 1'b1;
    case (state)
      ARB: begin
        if (grant[P_DBG] && p1_lock) begin
          state_nxt    = LOCK;
          lock_cnt_nxt = '0;
        end
      end
      LOCK: begin
        lock_cnt_nxt = lock_cnt + 1'b1;
        // Leaving LOCK hands priority to the CPU for the next contended cycle.
        if (!p1_lock || lock_cnt == CNT_W'(LOCK_MAX - 1)) begin
          state_nxt      = ARB;
          last_grant_nxt = 1'b1;
        end
      end
      default: state_nxt = ARB;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= ARB;
      last_grant <= 1'b1;
      lock_cnt   <= '0;
      rd_pend    <= 1'b0;
      rd_owner   <= 1'b0;
    end else begin
      state      <= state_nxt;
      last_grant <= last_grant_nxt;
      lock_cnt   <= lock_cnt_nxt;
      rd_pend    <= mem_en && !mem_we;
      rd_owner   <= grant[P_DBG];
    end
  end

  assign p0.rvalid = reset && rd_pend && !rd_owner;
  assign p1.rvalid = reset && rd_pend && rd_owner;
  assign p0.rdata  = p0.rvalid ? mem_rdata : '0;
  assign p1.rdata  = p1.rvalid ? mem_rdata : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed vector table, lock/reset sequences, then random traffic vs a reference model.
module tb_dmem_arbiter;

  localparam int AW   = 4;
  localparam int DW   = 16;
  localparam int LMAX = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          p1_lock = 1'b0;
  logic          locked, mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;

  dmem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) p0_if ();
  dmem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) p1_if ();

  dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .LOCK_MAX(LMAX)) dut (
    .clk       (clk),
    .reset     (reset),
    .p0        (p0_if),
    .p1        (p1_if),
    .p1_lock   (p1_lock),
    .locked    (locked),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;

  // Synchronous memory behind the arbiter; dmem[i] starts at 100*(i+1).
  logic [DW-1:0] dmem [16];
  logic          mem_loaded = 1'b0;
  always @(posedge clk) begin
    if (!mem_loaded) begin
      for (int i = 0; i < 16; i++) dmem[i] <= DW'(100 * (i + 1));
      mem_loaded <= 1'b1;
    end else if (mem_en) begin
      if (mem_we) dmem[mem_addr] <= mem_wdata;
      else        mem_rdata <= dmem[mem_addr];
    end
  end

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: who may go next, how many lock cycles remain, outstanding read.
  logic [DW-1:0] m_mem [16];
  bit            m_lock = 1'b0;
  int            m_left = 0;
  int            m_pref = 0;
  bit            m_pend = 1'b0;
  int            m_pend_port = 0;
  logic [DW-1:0] m_pend_data = '0;
  int            m_g = -1;

  logic          s_rdy0, s_rdy1, s_en, s_we, s_lck, s_rv0, s_rv1;
  logic [DW-1:0] s_rd0, s_rd1;

  task automatic port_req(input int g, output logic w, output logic [AW-1:0] a, output logic [DW-1:0] d);
    if (g == 0) begin w = p0_if.we; a = p0_if.addr; d = p0_if.wdata; end
    else        begin w = p1_if.we; a = p1_if.addr; d = p1_if.wdata; end
  endtask

  task automatic model_check();
    int            g;
    logic          w, erv0, erv1;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    g = -1;
    if (reset) begin
      if (m_lock)                            g = p1_if.valid ? 1 : -1;
      else if (p0_if.valid && p1_if.valid)   g = m_pref;
      else if (p0_if.valid)                  g = 0;
      else if (p1_if.valid)                  g = 1;
    end
    m_g = g;
    s_rdy0 = p0_if.ready;  s_rdy1 = p1_if.ready;
    s_en   = mem_en;       s_we   = mem_we;  s_lck = locked;
    s_rv0  = p0_if.rvalid; s_rd0  = p0_if.rdata;
    s_rv1  = p1_if.rvalid; s_rd1  = p1_if.rdata;
    chk("m.ready0", s_rdy0, g == 0);
    chk("m.ready1", s_rdy1, g == 1);
    chk("m.mem_en", s_en, g >= 0);
    if (g >= 0) begin
      port_req(g, w, a, d);
      chk("m.mem_we", s_we, w);
      chk("m.mem_addr", mem_addr, a);
      if (w) chk("m.mem_wdata", mem_wdata, d);
    end else begin
      chk("m.mem_we_idle", s_we, 0);
    end
    chk("m.locked", s_lck, reset && m_lock);
    erv0 = reset && m_pend && m_pend_port == 0;
    erv1 = reset && m_pend && m_pend_port == 1;
    chk("m.rvalid0", s_rv0, erv0);
    chk("m.rdata0", s_rd0, erv0 ? m_pend_data : '0);
    chk("m.rvalid1", s_rv1, erv1);
    chk("m.rdata1", s_rd1, erv1 ? m_pend_data : '0);
  endtask

  task automatic model_advance();
    logic          w;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    if (!reset) begin
      m_lock = 1'b0; m_left = 0; m_pref = 0; m_pend = 1'b0;
      return;
    end
    m_pend = 1'b0;
    if (m_g >= 0) begin
      port_req(m_g, w, a, d);
      if (w) m_mem[a] = d;
      else begin m_pend = 1'b1; m_pend_port = m_g; m_pend_data = m_mem[a]; end
      m_pref = 1 - m_g;
    end
    if (m_lock) begin
      m_left--;
      if (!p1_lock || m_left == 0) begin m_lock = 1'b0; m_pref = 0; end
    end else if (m_g == 1 && p1_lock) begin
      m_lock = 1'b1; m_left = LMAX;
    end
  endtask

  task automatic cycle(input logic r,
                       input logic v0, input logic w0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                       input logic v1, input logic w1, input logic [AW-1:0] a1, input logic [DW-1:0] d1,
                       input logic lk);
    reset = r;
    p0_if.valid = v0; p0_if.we = w0; p0_if.addr = a0; p0_if.wdata = d0;
    p1_if.valid = v1; p1_if.we = w1; p1_if.addr = a1; p1_if.wdata = d1;
    p1_lock = lk;
    @(negedge clk);
    model_check();
    @(posedge clk);
    model_advance();
    #1;
  endtask

  typedef struct {
    logic r, v0, w0; logic [AW-1:0] a0; logic [DW-1:0] d0;
    logic v1, w1;    logic [AW-1:0] a1; logic [DW-1:0] d1;
    logic lk;
    logic e_rdy0, e_rdy1, e_en, e_we, e_rv0; logic [DW-1:0] e_rd0;
    logic e_rv1; logic [DW-1:0] e_rd1; logic e_lck;
  } vec_t;

  vec_t tbl [12];

  logic          rv, rp0, rp1, rlk, rw0, rw1;
  logic [AW-1:0] ra0, ra1;
  logic [DW-1:0] rd0, rd1;
  bit            pend0, pend1;
  int            lck_n;

  initial begin
    for (int i = 0; i < 16; i++) m_mem[i] = DW'(100 * (i + 1));
    p0_if.valid = 0; p0_if.we = 0; p0_if.addr = '0; p0_if.wdata = '0;
    p1_if.valid = 0; p1_if.we = 0; p1_if.addr = '0; p1_if.wdata = '0;

    //          r  v0 w0 a0 d0         v1 w1 a1 d1        lk rdy0 rdy1 en we rv0 rd0         rv1 rd1      lck
    tbl[0]  = '{0, 1, 0, 1, 16'h0,     0, 0, 0, 16'h0,    0, 0, 0, 0, 0, 0, 16'd0,     0, 16'd0,   0};
    tbl[1]  = '{0, 1, 0, 1, 16'h0,     0, 0, 0, 16'h0,    0, 0, 0, 0, 0, 0, 16'd0,     0, 16'd0,   0};
    tbl[2]  = '{1, 1, 0, 1, 16'h0,     0, 0, 0, 16'h0,    0, 1, 0, 1, 0, 0, 16'd0,     0, 16'd0,   0};
    tbl[3]  = '{1, 0, 0, 0, 16'h0,     0, 0, 0, 16'h0,    0, 0, 0, 0, 0, 1, 16'd200,   0, 16'd0,   0};
    tbl[4]  = '{1, 1, 0, 3, 16'h0,     1, 0, 4, 16'h0,    0, 0, 1, 1, 0, 0, 16'd0,     0, 16'd0,   0};
    tbl[5]  = '{1, 1, 0, 3, 16'h0,     1, 0, 5, 16'h0,    0, 1, 0, 1, 0, 0, 16'd0,     1, 16'd500, 0};
    tbl[6]  = '{1, 1, 0, 6, 16'h0,     1, 0, 5, 16'h0,    0, 0, 1, 1, 0, 1, 16'd400,   0, 16'd0,   0};
    tbl[7]  = '{1, 1, 0, 6, 16'h0,     0, 0, 0, 16'h0,    0, 1, 0, 1, 0, 0, 16'd0,     1, 16'd600, 0};
    tbl[8]  = '{1, 0, 0, 0, 16'h0,     0, 0, 0, 16'h0,    0, 0, 0, 0, 0, 1, 16'd700,   0, 16'd0,   0};
    tbl[9]  = '{1, 0, 0, 0, 16'h0,     1, 1, 2, 16'h1234, 0, 0, 1, 1, 1, 0, 16'd0,     0, 16'd0,   0};
    tbl[10] = '{1, 1, 0, 2, 16'h0,     0, 0, 0, 16'h0,    0, 1, 0, 1, 0, 0, 16'd0,     0, 16'd0,   0};
    tbl[11] = '{1, 0, 0, 0, 16'h0,     0, 0, 0, 16'h0,    0, 0, 0, 0, 0, 1, 16'h1234,  0, 16'd0,   0};

    @(posedge clk);
    #1;

    for (int i = 0; i < 12; i++) begin
      cycle(tbl[i].r, tbl[i].v0, tbl[i].w0, tbl[i].a0, tbl[i].d0,
            tbl[i].v1, tbl[i].w1, tbl[i].a1, tbl[i].d1, tbl[i].lk);
      chk($sformatf("tbl%0d.ready0", i), s_rdy0, tbl[i].e_rdy0);
      chk($sformatf("tbl%0d.ready1", i), s_rdy1, tbl[i].e_rdy1);
      chk($sformatf("tbl%0d.mem_en", i), s_en, tbl[i].e_en);
      chk($sformatf("tbl%0d.mem_we", i), s_we, tbl[i].e_we);
      chk($sformatf("tbl%0d.rvalid0", i), s_rv0, tbl[i].e_rv0);
      chk($sformatf("tbl%0d.rdata0", i), s_rd0, tbl[i].e_rd0);
      chk($sformatf("tbl%0d.rvalid1", i), s_rv1, tbl[i].e_rv1);
      chk($sformatf("tbl%0d.rdata1", i), s_rd1, tbl[i].e_rd1);
      chk($sformatf("tbl%0d.locked", i), s_lck, tbl[i].e_lck);
    end

    // Full-length lock: 1 ARB grant + LOCK_MAX locked grants to port 1, then port 0.
    lck_n = 0;
    for (int c = 0; c < 10; c++) begin
      cycle(1, 1, 0, 4'd0, 16'd0, 1, 0, AW'(c), 16'd0, 1);
      if (s_lck) lck_n++;
      if (c < 9) chk($sformatf("lockmax.p1_grant%0d", c), s_rdy1, 1);
    end
    chk("lockmax.p0_after", s_rdy0, 1);
    chk("lockmax.locked_cycles", lck_n, LMAX);

    // Lock released early: lock dropped in the 4th LOCK cycle.
    for (int c = 0; c < 7; c++) begin
      cycle(1, c < 6, 0, 4'd8, 16'd0, 1, 0, 4'd9, 16'd0, c < 4);
      if (c == 4) chk("lockdrop.still_locked", s_lck, 1);
      if (c == 5) begin
        chk("lockdrop.unlocked", s_lck, 0);
        chk("lockdrop.p0_wins", s_rdy0, 1);
      end
    end

    // Reset right after a read accept suppresses its response.
    cycle(1, 1, 0, 4'd7, 16'd0, 0, 0, 4'd0, 16'd0, 0);
    chk("rstrd.accept", s_rdy0, 1);
    cycle(0, 0, 0, 4'd0, 16'd0, 0, 0, 4'd0, 16'd0, 0);
    chk("rstrd.no_rvalid", s_rv0, 0);
    cycle(1, 0, 0, 4'd0, 16'd0, 0, 0, 4'd0, 16'd0, 0);
    chk("rstrd.no_rvalid_late", s_rv0, 0);
    cycle(1, 1, 0, 4'd1, 16'd0, 1, 0, 4'd2, 16'd0, 0);
    chk("rstrd.p0_first", s_rdy0, 1);
    cycle(1, 0, 0, 4'd0, 16'd0, 1, 0, 4'd2, 16'd0, 0);

    // Random traffic; requests stay stable until the model says they were accepted.
    pend0 = 0; pend1 = 0;
    rp0 = 0; rw0 = 0; ra0 = '0; rd0 = '0;
    rp1 = 0; rw1 = 0; ra1 = '0; rd1 = '0;
    for (int n = 0; n < 600; n++) begin
      rv = ($urandom_range(0, 60) != 0);
      if (!pend0) begin
        rp0 = ($urandom_range(0, 2) != 0); rw0 = 1'($urandom_range(0, 1));
        ra0 = AW'($urandom_range(0, 15));  rd0 = DW'($urandom);
      end
      if (!pend1) begin
        rp1 = ($urandom_range(0, 2) != 0); rw1 = 1'($urandom_range(0, 1));
        ra1 = AW'($urandom_range(0, 15));  rd1 = DW'($urandom);
      end
      rlk = ($urandom_range(0, 3) != 0);
      cycle(rv, rp0, rw0, ra0, rd0, rp1, rw1, ra1, rd1, rlk);
      pend0 = rp0 && (m_g != 0);
      pend1 = rp1 && (m_g != 1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
